agendador_cafe: RTL and testbench
=================================

AGENDADOR_CAFE -- requirements
Module: agendador_cafe

Interface
REQ-001 Parameter ACK_TIMEOUT, default 4: max cycles waiting for the machine to leave IDLE after start.
REQ-002 Parameter DONE_TIMEOUT, default 200: max cycles from machine acknowledge to return to IDLE.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  level request per requester 0..3; bit i high = requester i wants a coffee.
REQ-006 maq_state  input  4  coffee machine state code: 1 IDLE, 2 LIGAR, 3 VERIFICAR_AGUA, 4 ENCHER, 5 MOER, 6 FILTRO, 7 AGITADOR, 8 TAMPEAR, 9 EXTRACAO.
REQ-007 erro_clr  input  1  one-cycle pulse that clears the error condition.
REQ-008 maq_start  output  1  start pulse to the machine.
REQ-009 grant  output  4  one-hot; identifies the requester currently being served, 0 when none.
REQ-010 done  output  4  one-cycle pulse on bit i when requester i's coffee completes.
REQ-011 busy  output  1  high in every state except C_IDLE and C_ERRO.
REQ-012 erro  output  1  high while in C_ERRO.
REQ-013 copos  output  8  count of completed coffees, saturating at 255.
REQ-014 ctrl_state  output  3  current controller state code.

Function
REQ-015 The controller SHALL be a registered FSM: C_IDLE=0, C_START=1, C_WAIT_ACK=2, C_WAIT_DONE=3, C_DONE=4, C_ERRO=5.
REQ-016 C_IDLE: if req != 0 and maq_state == 1, the controller SHALL select a winner round-robin starting at (last+1) mod 4, register grant one-hot and go to C_START; otherwise it stays in C_IDLE.
REQ-017 last resets to 3, so the first arbitration favours requester 0.
REQ-018 C_START: maq_start SHALL be 1 for exactly this one cycle, then the FSM goes to C_WAIT_ACK; maq_start SHALL be 0 in all other states.
REQ-019 An 8-bit timer SHALL clear on entry to C_WAIT_ACK and C_WAIT_DONE, and increment each cycle spent in either state.
REQ-020 C_WAIT_ACK: maq_state == 2 -> C_WAIT_DONE; else timer == ACK_TIMEOUT -> C_ERRO; else stay.
REQ-021 C_WAIT_DONE: flag seen9 clears on entry and sets when maq_state == 9.
REQ-022 C_WAIT_DONE exit: maq_state == 1 with seen9 set -> C_DONE; else timer == DONE_TIMEOUT -> C_ERRO; else stay.
REQ-023 maq_state == 1 without seen9 in C_WAIT_DONE SHALL NOT complete the order; the timeout rule applies.
REQ-024 C_DONE (one cycle): done = grant, copos += 1 unless already 255, last = granted index; next cycle grant = 0 and state C_IDLE.
REQ-025 grant SHALL remain constant from C_START through C_DONE; deasserting req mid-order SHALL NOT cancel or alter the order.
REQ-026 A requester holding req after done SHALL be rearbitrated normally and cannot win twice in a row while others are requesting.
REQ-027 C_ERRO: grant = 0, busy = 0, erro = 1, no maq_start; erro_clr -> C_IDLE next cycle, with last unchanged and copos unchanged.
REQ-028 erro_clr in any state other than C_ERRO SHALL be ignored.
REQ-029 At most one done bit SHALL be high at any time, and at most one order SHALL be in flight.

Reset
REQ-030 On reset assertion the controller SHALL enter C_IDLE immediately, without waiting for a clock edge.
REQ-031 Reset values: maq_start=0, grant=0, done=0, busy=0, erro=0, copos=0, ctrl_state=0, timer=0, seen9=0, last=3.
REQ-032 Reset mid-order SHALL abort the order with no done pulse and no copos increment.

Verification
REQ-033 req=0001, machine model agua_enchida=1: maq_start one pulse; maq_state runs 2,3,5,6,7,8,9,1 -> done=0001 one cycle, copos=1, grant=0 after.
REQ-034 req=1111 held, 5 orders: grant sequence 0001,0010,0100,1000,0001 -> copos=5, each done bit pulsed per its grant.
REQ-035 Machine model agua_enchida=0 for 3 checks (3,4,3,4,3,4,3,5..9,1) -> completes without error; done=0001.
REQ-036 maq_state held at 1 after maq_start -> erro=1 after ACK_TIMEOUT+1 cycles in C_WAIT_ACK; grant=0; erro_clr -> C_IDLE; copos unchanged.
REQ-037 Reset asserted while in C_WAIT_DONE (maq_state=6) -> all outputs at reset values, no done pulse, copos=0.
REQ-038 copos preloaded to 255 via 255 orders, one more order -> done pulses, copos stays 255.

Source files
------------

// File: rtl/agendador_cafe.sv
`default_nettype none
// ============================================================================
//  Module      : agendador_cafe
//  Description : Round-robin order scheduler for a shared coffee machine.
//                Four requesters compete for the machine. One order is
//                started at a time. Completion requires the machine to pass
//                through EXTRACAO and return to IDLE. Both the acknowledge
//                wait and the brew wait are guarded by timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module agendador_cafe #(
    parameter int ACK_TIMEOUT  = 4,
    parameter int DONE_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] maq_state,
    input  logic       erro_clr,
    output logic       maq_start,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic       busy,
    output logic       erro,
    output logic [7:0] copos,
    output logic [2:0] ctrl_state
);

    // Controller state encoding (visible on ctrl_state)
    typedef enum logic [2:0] {
        C_IDLE      = 3'd0,
        C_START     = 3'd1,
        C_WAIT_ACK  = 3'd2,
        C_WAIT_DONE = 3'd3,
        C_DONE      = 3'd4,
        C_ERRO      = 3'd5
    } ctrl_t;

    // Machine state codes this controller reacts to
    localparam logic [3:0] M_IDLE     = 4'd1;
    localparam logic [3:0] M_LIGAR    = 4'd2;
    localparam logic [3:0] M_EXTRACAO = 4'd9;

    localparam logic [7:0] ACK_LIMIT  = 8'(ACK_TIMEOUT);
    localparam logic [7:0] DONE_LIMIT = 8'(DONE_TIMEOUT);
    localparam logic [7:0] COPOS_MAX  = 8'd255;

    ctrl_t      state;
    logic [7:0] timer;
    logic       seen9;
    logic [1:0] last;
    logic [1:0] grant_idx;

    logic [1:0] pick_idx;
    logic       pick_valid;
    logic [1:0] cand;

    assign ctrl_state = state;

    // Round-robin search starting one past the last served requester
    always_comb begin
        pick_idx   = last;
        pick_valid = 1'b0;
        cand       = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!pick_valid && req[cand]) begin
                pick_idx   = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= C_IDLE;
            maq_start <= 1'b0;
            grant     <= 4'd0;
            grant_idx <= 2'd0;
            done      <= 4'd0;
            busy      <= 1'b0;
            erro      <= 1'b0;
            copos     <= 8'd0;
            timer     <= 8'd0;
            seen9     <= 1'b0;
            last      <= 2'd3;
        end else begin
            // Pulses default low; each is raised only on entry to its state
            maq_start <= 1'b0;
            done      <= 4'd0;

            case (state)
                C_IDLE: begin
                    if (pick_valid && maq_state == M_IDLE) begin
                        grant     <= 4'b0001 << pick_idx;
                        grant_idx <= pick_idx;
                        maq_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= C_START;
                    end
                end

                C_START: begin
                    timer <= 8'd0;
                    state <= C_WAIT_ACK;
                end

                C_WAIT_ACK: begin
                    if (maq_state == M_LIGAR) begin
                        timer <= 8'd0;
                        seen9 <= 1'b0;
                        state <= C_WAIT_DONE;
                    end else if (timer == ACK_LIMIT) begin
                        grant <= 4'd0;
                        busy  <= 1'b0;
                        erro  <= 1'b1;
                        state <= C_ERRO;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                C_WAIT_DONE: begin
                    // Returning to IDLE only counts once extraction was seen
                    if (maq_state == M_IDLE && seen9) begin
                        done  <= grant;
                        state <= C_DONE;
                    end else if (timer == DONE_LIMIT) begin
                        grant <= 4'd0;
                        busy  <= 1'b0;
                        erro  <= 1'b1;
                        state <= C_ERRO;
                    end else begin
                        timer <= timer + 8'd1;
                        if (maq_state == M_EXTRACAO) begin
                            seen9 <= 1'b1;
                        end
                    end
                end

                C_DONE: begin
                    if (copos != COPOS_MAX) begin
                        copos <= copos + 8'd1;
                    end
                    last  <= grant_idx;
                    grant <= 4'd0;
                    busy  <= 1'b0;
                    state <= C_IDLE;
                end

                C_ERRO: begin
                    if (erro_clr) begin
                        erro  <= 1'b0;
                        state <= C_IDLE;
                    end
                end

                default: begin
                    grant <= 4'd0;
                    busy  <= 1'b0;
                    erro  <= 1'b0;
                    state <= C_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_agendador_cafe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_agendador_cafe
//  Description : Self-checking bench for agendador_cafe: vector table,
//                directed corner sequences and randomized orders against a
//                round-robin / counting reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agendador_cafe;

    localparam int ACK_TIMEOUT  = 4;
    localparam int DONE_TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] maq_state;
    logic       erro_clr;
    logic       maq_start;
    logic [3:0] grant;
    logic [3:0] done;
    logic       busy;
    logic       erro;
    logic [7:0] copos;
    logic [2:0] ctrl_state;

    agendador_cafe #(
        .ACK_TIMEOUT  (ACK_TIMEOUT),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .maq_state  (maq_state),
        .erro_clr   (erro_clr),
        .maq_start  (maq_start),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .erro       (erro),
        .copos      (copos),
        .ctrl_state (ctrl_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_last  = 3;
    int m_copos = 0;

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        int         nw;
        logic [7:0] c;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester at or after (last+1) mod 4
    function automatic logic [3:0] rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (r[i]) return 4'b0001 << i;
        end
        return 4'b0000;
    endfunction

    task automatic model_complete(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) m_last = i;
        if (m_copos < 255) m_copos++;
    endtask

    task automatic do_reset();
        req = 4'd0; maq_state = 4'd1; erro_clr = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        m_last = 3; m_copos = 0;
    endtask

    // Full order: machine acks, does nw extra water-check loops, then brews
    task automatic do_order(input logic [3:0] r, input logic [3:0] exp_g,
                            input int nw, input logic [3:0] req_after);
        int q[$];
        req = r; maq_state = 4'd1;
        step();
        check("start_pulse", maq_start, 1);
        check("start_state", ctrl_state, 1);
        check("start_grant", grant, exp_g);
        check("start_busy", busy, 1);
        req = req_after;
        maq_state = 4'd2;
        step();
        check("ack_state", ctrl_state, 2);
        check("ack_no_start", maq_start, 0);
        step();
        check("wdone_state", ctrl_state, 3);
        q.push_back(3);
        for (int i = 0; i < nw; i++) begin q.push_back(4); q.push_back(3); end
        q.push_back(5); q.push_back(6); q.push_back(7);
        q.push_back(8); q.push_back(9); q.push_back(1);
        for (int i = 0; i < q.size(); i++) begin
            maq_state = 4'(q[i]);
            step();
            check("hold_grant", grant, exp_g);
            check("no_start", maq_start, 0);
            if (i < q.size() - 1) begin
                check("no_done", done, 0);
            end else begin
                check("done_state", ctrl_state, 4);
                check("done_pulse", done, exp_g);
            end
        end
        model_complete(exp_g);
        step();
        check("after_done", done, 0);
        check("after_grant", grant, 0);
        check("after_state", ctrl_state, 0);
        check("after_busy", busy, 0);
        check("copos", copos, m_copos);
    endtask

    // Machine never leaves IDLE after maq_start
    task automatic do_ack_timeout(input logic [3:0] r, input logic [3:0] exp_g);
        int n;
        req = r; maq_state = 4'd1;
        step();
        check("to_start_grant", grant, exp_g);
        req = 4'd0;
        step();
        n = 0;
        while (ctrl_state == 3'd2 && n < 20) begin
            n++;
            step();
        end
        check("ack_to_cycles", n, ACK_TIMEOUT + 1);
        check("ack_to_state", ctrl_state, 5);
        check("ack_to_erro", erro, 1);
        check("ack_to_grant", grant, 0);
        check("ack_to_busy", busy, 0);
        step(); step();
        check("erro_holds", erro, 1);
        check("erro_no_start", maq_start, 0);
        erro_clr = 1'b1;
        step();
        erro_clr = 1'b0;
        check("clr_state", ctrl_state, 0);
        check("clr_erro", erro, 0);
        check("clr_copos", copos, m_copos);
    endtask

    initial begin
        logic [3:0] r, g;
        int n;
        bit saw_done;

        // Reset values while reset is held
        req = 4'd0; maq_state = 4'd1; erro_clr = 1'b0; reset = 1'b1;
        #2;
        check("rst_state", ctrl_state, 0);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_erro", erro, 0);
        check("rst_copos", copos, 0);
        check("rst_start", maq_start, 0);
        do_reset();

        // Idle with no request stays idle
        step();
        check("idle_stay", ctrl_state, 0);

        // Vector table: 1111 held for 5 orders, then mixed patterns
        tbl[0] = '{4'b1111, 4'b0001, 0, 8'd1};
        tbl[1] = '{4'b1111, 4'b0010, 0, 8'd2};
        tbl[2] = '{4'b1111, 4'b0100, 0, 8'd3};
        tbl[3] = '{4'b1111, 4'b1000, 0, 8'd4};
        tbl[4] = '{4'b1111, 4'b0001, 0, 8'd5};
        tbl[5] = '{4'b0001, 4'b0001, 3, 8'd6};
        tbl[6] = '{4'b1001, 4'b1000, 0, 8'd7};
        tbl[7] = '{4'b0110, 4'b0010, 1, 8'd8};
        tbl[8] = '{4'b0011, 4'b0001, 0, 8'd9};
        tbl[9] = '{4'b0101, 4'b0100, 2, 8'd10};
        for (int i = 0; i < 10; i++) begin
            do_order(tbl[i].r, tbl[i].g, tbl[i].nw, tbl[i].r);
            check("tbl_copos", copos, tbl[i].c);
        end

        // Asynchronous reset while waiting for the brew
        req = 4'b0010; maq_state = 4'd1;
        step();
        check("rstmid_grant", grant, 4'b0010);
        maq_state = 4'd2;
        step(); step();
        maq_state = 4'd6;
        step();
        check("rstmid_wdone", ctrl_state, 3);
        #2 reset = 1'b1;
        #1;
        check("arst_state", ctrl_state, 0);
        check("arst_grant", grant, 0);
        check("arst_busy", busy, 0);
        check("arst_copos", copos, 0);
        check("arst_done", done, 0);
        req = 4'd0; maq_state = 4'd1;
        step();
        reset = 1'b0;
        m_last = 3; m_copos = 0;
        step();
        check("arst_no_done", done, 0);
        check("arst_copos2", copos, 0);
        do_order(4'b1111, 4'b0001, 0, 4'b1111);

        // Return to IDLE without extraction: must time out, erro_clr ignored
        g = rr_pick(4'b0010, m_last);
        req = 4'b0010; maq_state = 4'd1;
        step();
        check("dto_grant", grant, g);
        req = 4'd0; maq_state = 4'd2;
        step(); step();
        maq_state = 4'd3;
        n = 0; saw_done = 1'b0;
        while (ctrl_state == 3'd3 && n < 400) begin
            n++;
            if (n == 2) maq_state = 4'd5;
            if (n == 3) maq_state = 4'd1;
            erro_clr = (n == 10);
            if (done != 4'd0) saw_done = 1'b1;
            step();
        end
        erro_clr = 1'b0;
        check("dto_cycles", n, DONE_TIMEOUT + 1);
        check("dto_no_done", saw_done, 0);
        check("dto_erro", erro, 1);
        check("dto_state", ctrl_state, 5);
        check("dto_copos", copos, m_copos);
        erro_clr = 1'b1;
        step();
        erro_clr = 1'b0;
        check("dto_clr", ctrl_state, 0);

        // Acknowledge timeout, last must be unchanged afterwards
        do_ack_timeout(4'b0001, rr_pick(4'b0001, m_last));
        do_order(4'b1111, rr_pick(4'b1111, m_last), 0, 4'b1111);

        // Randomized orders against the model
        for (int it = 0; it < 40; it++) begin
            r = 4'($urandom_range(1, 15));
            g = rr_pick(r, m_last);
            if ($urandom_range(0, 7) == 0) begin
                do_ack_timeout(r, g);
            end else begin
                do_order(r, g, int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 3) == 0) begin
                req = 4'd0;
                step();
                check("rnd_idle", ctrl_state, 0);
            end
        end

        // Saturation of the cup counter
        while (m_copos < 255) do_order(4'b0001, 4'b0001, 0, 4'b0001);
        check("sat_255", copos, 255);
        do_order(4'b0001, 4'b0001, 0, 4'b0001);
        check("sat_hold", copos, 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
